// File: rtl/alu_pkg.sv
// Shared definitions for the ALU response checker: opcode encodings,
// operand width and checker FSM state type.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_AND = 2'b10;
    localparam logic [1:0] SEL_CMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU: computes every expected
// response field for the given operands and opcode.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic [1:0]      sel,
    output logic [OP_W:0]   exp_addsub,
    output logic [OP_W-1:0] exp_and,
    output logic            exp_eq,
    output logic            exp_gt,
    output logic            exp_lt
);

    logic [OP_W:0] a_ext;
    logic [OP_W:0] b_ext;

    always_comb begin
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        // Subtraction wraps modulo 32 through the 5-bit result.
        if (sel == SEL_SUB) begin
            exp_addsub = a_ext - b_ext;
        end else begin
            exp_addsub = a_ext + b_ext;
        end
        exp_and = a & b;
        exp_eq  = (a == b);
        exp_gt  = (a > b);
        exp_lt  = (a < b);
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Two-stage ALU response checker with pass/fail counters and run FSM.
// Define ALU_CHK_CAPTURE_EN to capture the operands of the first mismatch.
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [1:0]       sel,
    input  logic [OP_W:0]    y_addsub,
    input  logic [OP_W-1:0]  y_and,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef ALU_CHK_CAPTURE_EN
    ,
    output logic [OP_W-1:0]  fail_a,
    output logic [OP_W-1:0]  fail_b,
    output logic [1:0]       fail_sel
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;

    logic             s1_vld_q, s1_vld_d;
    logic [OP_W-1:0]  s1_a_q, s1_a_d;
    logic [OP_W-1:0]  s1_b_q, s1_b_d;
    logic [1:0]       s1_sel_q, s1_sel_d;
    logic [OP_W:0]    s1_addsub_q, s1_addsub_d;
    logic [OP_W-1:0]  s1_and_q, s1_and_d;
    logic [2:0]       s1_cmp_q, s1_cmp_d;

    logic             s2_vld_q, s2_vld_d;
    logic             s2_pass_q, s2_pass_d;

`ifdef ALU_CHK_CAPTURE_EN
    logic [OP_W-1:0]  s2_a_q, s2_a_d;
    logic [OP_W-1:0]  s2_b_q, s2_b_d;
    logic [1:0]       s2_sel_q, s2_sel_d;
    logic [OP_W-1:0]  fail_a_q, fail_a_d;
    logic [OP_W-1:0]  fail_b_q, fail_b_d;
    logic [1:0]       fail_sel_q, fail_sel_d;
`endif

    logic [OP_W:0]    exp_addsub;
    logic [OP_W-1:0]  exp_and;
    logic             exp_eq, exp_gt, exp_lt;
    logic             match;
    logic             fire;
    logic             start_ok;
    logic [CNT_W-1:0] chk_next;

    alu_ref_model u_ref (
        .a          (s1_a_q),
        .b          (s1_b_q),
        .sel        (s1_sel_q),
        .exp_addsub (exp_addsub),
        .exp_and    (exp_and),
        .exp_eq     (exp_eq),
        .exp_gt     (exp_gt),
        .exp_lt     (exp_lt)
    );

    assign in_ready = (state_q == RUN) && (acc_q < num_q);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign fire     = in_valid && in_ready;
    assign start_ok = start && (state_q != RUN);

`ifdef ALU_CHK_CAPTURE_EN
    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_sel = fail_sel_q;
`endif

    // Only the fields belonging to the active opcode are judged.
    always_comb begin
        match = 1'b0;
        unique case (s1_sel_q)
            SEL_ADD, SEL_SUB: match = (s1_addsub_q == exp_addsub);
            SEL_AND:          match = (s1_and_q == exp_and);
            SEL_CMP:          match = (s1_cmp_q == {exp_eq, exp_gt, exp_lt});
            default:          match = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        acc_d       = acc_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        err_d       = err_q;
        s1_vld_d    = fire;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_sel_d    = s1_sel_q;
        s1_addsub_d = s1_addsub_q;
        s1_and_d    = s1_and_q;
        s1_cmp_d    = s1_cmp_q;
        s2_vld_d    = s1_vld_q;
        s2_pass_d   = match;
        chk_next    = pass_q + fail_q + CNT_W'(s2_vld_q);
`ifdef ALU_CHK_CAPTURE_EN
        s2_a_d      = s1_a_q;
        s2_b_d      = s1_b_q;
        s2_sel_d    = s1_sel_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_sel_d  = fail_sel_q;
`endif

        if (fire) begin
            s1_a_d      = a;
            s1_b_d      = b;
            s1_sel_d    = sel;
            s1_addsub_d = y_addsub;
            s1_and_d    = y_and;
            s1_cmp_d    = {eq, gt, lt};
        end

        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                acc_d = acc_q + CNT_W'(fire);
                if (s2_vld_q && s2_pass_q) begin
                    pass_d = pass_q + 1'b1;
                end else if (s2_vld_q) begin
                    fail_d = fail_q + 1'b1;
                    err_d  = 1'b1;
`ifdef ALU_CHK_CAPTURE_EN
                    if (!err_q) begin
                        fail_a_d   = s2_a_q;
                        fail_b_d   = s2_b_q;
                        fail_sel_d = s2_sel_q;
                    end
`endif
                end
                if (chk_next == num_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        if (start_ok) begin
            state_d = RUN;
            num_d   = num_vec;
            acc_d   = '0;
            pass_d  = '0;
            fail_d  = '0;
            err_d   = 1'b0;
`ifdef ALU_CHK_CAPTURE_EN
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_sel_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            acc_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            err_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sel_q    <= '0;
            s1_addsub_q <= '0;
            s1_and_q    <= '0;
            s1_cmp_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_pass_q   <= 1'b0;
`ifdef ALU_CHK_CAPTURE_EN
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s2_sel_q    <= '0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_sel_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            acc_q       <= acc_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
            s1_vld_q    <= s1_vld_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sel_q    <= s1_sel_d;
            s1_addsub_q <= s1_addsub_d;
            s1_and_q    <= s1_and_d;
            s1_cmp_q    <= s1_cmp_d;
            s2_vld_q    <= s2_vld_d;
            s2_pass_q   <= s2_pass_d;
`ifdef ALU_CHK_CAPTURE_EN
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s2_sel_q    <= s2_sel_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_sel_q  <= fail_sel_d;
`endif
        end
    end

endmodule
